prog_instruction_ram: RTL and testbench

Parametrised, run-time loadable instruction memory for the processor fetch stage. It replaces fixed, elaboration-time program images with a streamed load: the block clears the array, accepts a program word-by-word over a valid/ready handshake, then serves registered fetches. Fetches outside the loaded region return a NOP word with a fault flag.

---
 rtl/prog_instruction_ram_if.sv | 34 +++
 rtl/prog_instruction_ram.sv | 112 +++++++++++
 tb/tb_prog_instruction_ram.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/prog_instruction_ram_if.sv
// rtl/prog_instruction_ram_if.sv - load stream and fetch port bundle for prog_instruction_ram
interface prog_instruction_ram_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  load_start;
    logic                  load_valid;
    logic                  load_last;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_ready;
    logic                  load_done;
    logic                  load_overflow;
    logic [ADDR_WIDTH:0]   load_count;
    logic                  busy;
    logic                  fetch_en;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic [DATA_WIDTH-1:0] fetch_data;
    logic                  fetch_valid;
    logic                  fetch_fault;

    modport master (
        output load_start, load_valid, load_last, load_data,
        output fetch_en, fetch_addr,
        input  load_ready, load_done, load_overflow, load_count, busy,
        input  fetch_data, fetch_valid, fetch_fault
    );

    modport slave (
        input  load_start, load_valid, load_last, load_data,
        input  fetch_en, fetch_addr,
        output load_ready, load_done, load_overflow, load_count, busy,
        output fetch_data, fetch_valid, fetch_fault
    );
endinterface

// File: rtl/prog_instruction_ram.sv
// rtl/prog_instruction_ram.sv - run-time loadable instruction memory with clear, streamed load and faulting fetch
module prog_instruction_ram #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DEPTH      = 1024,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    prog_instruction_ram_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(DEPTH - 1);

    state_t                state;
    logic [IDX_W-1:0]      ptr;
    logic [ADDR_WIDTH:0]   load_count_q;
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic                  accept;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  fetch_hit;

    assign accept    = (state == LOAD) && bus.load_valid;
    assign mem_we    = (state == CLEAR) || accept;
    assign mem_wdata = (state == CLEAR) ? NOP_WORD : bus.load_data;

    // Anything at or beyond the loaded length faults, which also covers addresses past DEPTH.
    assign fetch_hit = ({1'b0, bus.fetch_addr} < load_count_q);

    assign bus.load_count = load_count_q;

    // Array is deliberately left without reset; load_count = 0 keeps stale contents unreachable.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[ptr] <= mem_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            ptr               <= '0;
            load_count_q      <= '0;
            bus.load_ready    <= 1'b0;
            bus.load_done     <= 1'b0;
            bus.load_overflow <= 1'b0;
            bus.busy          <= 1'b0;
            bus.fetch_valid   <= 1'b0;
            bus.fetch_fault   <= 1'b0;
            bus.fetch_data    <= NOP_WORD;
        end else begin
            bus.load_done   <= 1'b0;
            bus.fetch_valid <= 1'b0;

            // A fetch sampled in RUN completes even when load_start moves us to CLEAR on the same edge.
            if ((state == RUN) && bus.fetch_en) begin
                bus.fetch_valid <= 1'b1;
                bus.fetch_fault <= !fetch_hit;
                bus.fetch_data  <= fetch_hit ? mem[bus.fetch_addr[IDX_W-1:0]] : NOP_WORD;
            end

            case (state)
                IDLE, RUN: begin
                    if (bus.load_start) begin
                        state             <= CLEAR;
                        ptr               <= '0;
                        load_count_q      <= '0;
                        bus.load_overflow <= 1'b0;
                        bus.busy          <= 1'b1;
                    end
                end

                CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST_PTR) begin
                        state          <= LOAD;
                        ptr            <= '0;
                        bus.load_ready <= 1'b1;
                    end
                end

                LOAD: begin
                    if (accept) begin
                        ptr          <= ptr + 1'b1;
                        load_count_q <= load_count_q + 1'b1;
                        if (bus.load_last || (ptr == LAST_PTR)) begin
                            state          <= RUN;
                            ptr            <= '0;
                            bus.load_ready <= 1'b0;
                            bus.busy       <= 1'b0;
                            bus.load_done  <= 1'b1;
                            if (!bus.load_last) begin
                                bus.load_overflow <= 1'b1;
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_instruction_ram.sv
// tb/tb_prog_instruction_ram.sv - directed self-checking bench for prog_instruction_ram
module tb_prog_instruction_ram;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    prog_instruction_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    prog_instruction_ram #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH),
        .NOP_WORD  (32'h0000_0000)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_load(input bit with_fetch, input logic [31:0] exp_word);
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        bus.fetch_en   = 1'b0;
        if (with_fetch) begin
            check("start_fetch_valid", bus.fetch_valid, 1'b1);
            check("start_fetch_data", bus.fetch_data, exp_word);
        end
        check("clear_busy", bus.busy, 1'b1);
        check("clear_count", bus.load_count, 0);
        check("clear_overflow", bus.load_overflow, 1'b0);
        repeat (DEPTH - 1) tick();
        check("clear_len_ready_low", bus.load_ready, 1'b0);
        tick();
        check("clear_len_ready_high", bus.load_ready, 1'b1);
    endtask

    task automatic send(input logic [31:0] word, input bit last);
        bus.load_valid = 1'b1;
        bus.load_data  = word;
        bus.load_last  = last;
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic fetch_chk(input string tag, input logic [AW-1:0] addr,
                             input logic [31:0] exp_data, input bit exp_fault);
        bus.fetch_en   = 1'b1;
        bus.fetch_addr = addr;
        tick();
        bus.fetch_en = 1'b0;
        check({tag, "_valid"}, bus.fetch_valid, 1'b1);
        check({tag, "_fault"}, bus.fetch_fault, exp_fault);
        check({tag, "_data"}, bus.fetch_data, exp_data);
    endtask

    initial begin
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        bus.load_data  = '0;
        bus.fetch_en   = 1'b0;
        bus.fetch_addr = '0;

        repeat (3) @(posedge clock);
        #1;
        check("rst_ready", bus.load_ready, 1'b0);
        check("rst_done", bus.load_done, 1'b0);
        check("rst_overflow", bus.load_overflow, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_count", bus.load_count, 0);
        check("rst_fvalid", bus.fetch_valid, 1'b0);
        check("rst_ffault", bus.fetch_fault, 1'b0);
        check("rst_fdata", bus.fetch_data, 32'h0);

        @(negedge clock);
        reset = 1'b1;
        tick();

        // IDLE ignores fetches
        bus.fetch_en   = 1'b1;
        bus.fetch_addr = 5'd0;
        tick();
        bus.fetch_en = 1'b0;
        check("idle_fetch_valid", bus.fetch_valid, 1'b0);
        check("idle_fetch_data", bus.fetch_data, 32'h0);

        // normal load of five words
        start_load(1'b0, 32'h0);
        send(32'hA000_0001, 1'b0);
        check("load_count_1", bus.load_count, 1);
        check("load_done_mid", bus.load_done, 1'b0);
        for (int i = 2; i <= 4; i++) send(32'hA000_0000 + i, 1'b0);
        send(32'hA000_0005, 1'b1);
        check("norm_done", bus.load_done, 1'b1);
        check("norm_ready_low", bus.load_ready, 1'b0);
        check("norm_busy", bus.busy, 1'b0);
        check("norm_count", bus.load_count, 5);
        check("norm_overflow", bus.load_overflow, 1'b0);
        for (int i = 0; i < 5; i++) begin
            fetch_chk("norm_fetch", 5'(i), 32'hA000_0001 + i, 1'b0);
        end
        tick();
        check("fetch_valid_pulse", bus.fetch_valid, 1'b0);
        check("done_pulse_gone", bus.load_done, 1'b0);
        fetch_chk("fetch5", 5'd5, 32'h0, 1'b1);
        fetch_chk("fetch15", 5'd15, 32'h0, 1'b1);
        fetch_chk("fetch20", 5'd20, 32'h0, 1'b1);

        // reload from RUN with a concurrent fetch, gaps and a stray load_last
        bus.fetch_en   = 1'b1;
        bus.fetch_addr = 5'd0;
        start_load(1'b1, 32'hA000_0001);
        send(32'hB000_0001, 1'b0);
        bus.load_last = 1'b1;
        tick();
        bus.load_last = 1'b0;
        check("gap_ready", bus.load_ready, 1'b1);
        check("gap_count", bus.load_count, 1);
        check("gap_done", bus.load_done, 1'b0);
        tick();
        send(32'hB000_0002, 1'b1);
        check("reload_done", bus.load_done, 1'b1);
        check("reload_count", bus.load_count, 2);
        fetch_chk("reload_f0", 5'd0, 32'hB000_0001, 1'b0);
        fetch_chk("reload_f1", 5'd1, 32'hB000_0002, 1'b0);
        fetch_chk("reload_f3", 5'd3, 32'h0, 1'b1);

        // overflow: DEPTH words without load_last
        start_load(1'b0, 32'h0);
        for (int i = 0; i < DEPTH - 1; i++) send(32'hC000_0000 + i, 1'b0);
        check("ovf_ready_before_last", bus.load_ready, 1'b1);
        check("ovf_flag_before_last", bus.load_overflow, 1'b0);
        send(32'hC000_000F, 1'b0);
        check("ovf_done", bus.load_done, 1'b1);
        check("ovf_flag", bus.load_overflow, 1'b1);
        check("ovf_count", bus.load_count, 16);
        check("ovf_ready_low", bus.load_ready, 1'b0);
        fetch_chk("ovf_f15", 5'd15, 32'hC000_000F, 1'b0);
        fetch_chk("ovf_f16", 5'd16, 32'h0, 1'b1);

        // asynchronous reset in the middle of a load
        start_load(1'b0, 32'h0);
        for (int i = 1; i <= 3; i++) send(32'hD000_0000 + i, 1'b0);
        check("pre_rst_count", bus.load_count, 3);
        #2;
        reset = 1'b0;
        #1;
        check("arst_busy", bus.busy, 1'b0);
        check("arst_ready", bus.load_ready, 1'b0);
        check("arst_count", bus.load_count, 0);
        check("arst_done", bus.load_done, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        tick();
        check("arst_no_done", bus.load_done, 1'b0);

        start_load(1'b0, 32'h0);
        send(32'hE000_0001, 1'b1);
        check("post_rst_count", bus.load_count, 1);
        fetch_chk("post_rst_f0", 5'd0, 32'hE000_0001, 1'b0);
        fetch_chk("post_rst_f1", 5'd1, 32'h0, 1'b1);
        fetch_chk("post_rst_f2", 5'd2, 32'h0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
